pll_dyn_ctrl: RTL and testbench
===============================

// Module: pll_dyn_ctrl
// PURPOSE
// Control/supervisor for a GTP_PLL_E3 instance configured with DYNAMIC_RATIOx_EN/DYNAMIC_DUTYx_EN="TRUE".
// Drives the PLL reset and per-channel output divider/duty buses, and filters the async LOCK.
// Supports run-time reprogramming of any of NUM_CH output dividers (e.g. HDMI pixel clock mode change).
// Produces a debounced locked flag and a downstream domain reset; retries on lock timeout.
// PARAMETERS
// NUM_CH        2                   number of PLL output channels driven (1..5)
// RW            10                  divider/duty field width, matches PLL RATIOx/DUTYx ports
// INIT_RATIO    {10'd12,10'd12}     flattened reset-time divider per channel, ch0 in LSBs
// RST_CYCLES    16                  cycles pll_rst is held high per (re)lock attempt
// LOCK_FILT     64                  consecutive synced-lock cycles required to declare lock
// LOCK_TIMEOUT  65536               cycles allowed in WAIT_LOCK before an attempt fails
// MAX_RETRY     3                   failed attempts before entering FAIL
// PORTS
// sys_clk       in   1          control clock (free-running, not a PLL output)
// sys_rst_n     in   1          synchronous active-low reset
// pll_lock      in   1          PLL LOCK, asynchronous to sys_clk
// cfg_valid     in   1          reprogram request
// cfg_ready     out  1          request accepted when cfg_valid & cfg_ready
// cfg_ch        in   3          target channel index
// cfg_ratio     in   RW         new divider value for cfg_ch
// cfg_err       out  1          1-cycle pulse: request rejected (ratio==0 or cfg_ch>=NUM_CH)
// pll_rst       out  1          to PLL RST, active high
// ratio_o       out  NUM_CH*RW  to PLL RATIO0..N-1
// duty_o        out  NUM_CH*RW  to PLL DUTY0..N-1 (always equals ratio_o: 50% duty)
// locked        out  1          filtered lock
// clk_rst_n     out  1          reset for PLL-clocked domains, active low
// fail          out  1          retries exhausted
// relock_cnt    out  8          count of lock losses while STABLE, saturates at 255
// BEHAVIOUR
// Reset (sys_rst_n=0 at sys_clk edge): state=RST, pll_rst=1, ratio_o=duty_o=INIT_RATIO, locked=0,
//   clk_rst_n=0, fail=0, cfg_ready=0, cfg_err=0, relock_cnt=0, retry=0, all counters 0.
// pll_lock passes through a 2-flop synchroniser (lock_s); all decisions use lock_s.
// States: RST -> WAIT_LOCK -> STABLE; WAIT_LOCK -> RST (retry) or FAIL.
// RST: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with pll_rst=0.
// WAIT_LOCK: filt counts cycles with lock_s=1 and clears to 0 on lock_s=0. When LOCK_FILT consecutive
//   lock_s=1 cycles have been seen -> STABLE; locked=1 and clk_rst_n=1 on that cycle; retry clears.
//   tmo counts every cycle; at LOCK_TIMEOUT cycles without reaching STABLE: retry+1; if retry==MAX_RETRY
//   -> FAIL, else -> RST.
// STABLE: lock_s=0 -> next cycle locked=0, clk_rst_n=0, relock_cnt+1 (saturating), -> RST.
// FAIL: pll_rst=1, fail=1, locked=0, clk_rst_n=0; exits only on accepted cfg or reset.
// cfg_ready = (state==STABLE || state==FAIL), registered from the state.
// Accept (cfg_valid & cfg_ready):
//   - if legal: ratio/duty field of cfg_ch updated next cycle, other channels unchanged;
//     locked=0, clk_rst_n=0, fail=0, retry=0; -> RST.
//   - if illegal: cfg_err=1 next cycle; no state change.
// Same-cycle legal accept and lock_s fall in STABLE: both take effect (new ratio applied, relock_cnt+1).
// ratio_o/duty_o change only while the next state is RST (PLL held in reset), never mid-lock.
// lock_s glitch of 1 cycle in WAIT_LOCK restarts the filter; tmo is not cleared.
// TESTING
// Reset, lock rises 100 cycles after release -> pll_rst low after 16 cycles; locked=1 exactly
//   64 cycles after lock_s=1 (2+64 after pll_lock); clk_rst_n rises with locked.
// In STABLE, cfg ch1 ratio=8 -> ratio_o=={10'd8,10'd12}, duty_o matches, pll_rst=1 for 16 cycles, relock.
// cfg_ratio=0, or cfg_ch=2 with NUM_CH=2 -> single cfg_err pulse; ratio_o, state and locked unchanged.
// pll_lock held 0 -> 3 timeouts of 65536 cycles, then fail=1, pll_rst=1; then valid cfg -> fail=0, retry.
// Drop pll_lock for 5 cycles in STABLE -> locked=0, relock_cnt=1, full relock; 300 drops -> relock_cnt=255.
// Assert sys_rst_n=0 mid-WAIT_LOCK after cfg -> all outputs at reset values, ratio_o back to INIT_RATIO.

Source files
------------

// File: rtl/pll_dyn_ctrl_if.sv
// Reprogramming request channel into the PLL supervisor: a valid/ready handshake carrying
// a channel index and a new divider, plus a one-cycle reject pulse back to the requester.
interface pll_dyn_ctrl_if #(
  parameter int unsigned RW = 10
) ();
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_ch;
  logic [RW-1:0] cfg_ratio;
  logic          cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_ratio,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_ratio,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Supervisor for a dynamically reconfigurable PLL: sequences PLL reset, filters the async
// lock, retries on lock timeout and applies run-time divider changes only while the PLL is
// held in reset.
module pll_dyn_ctrl #(
  parameter int unsigned          NUM_CH       = 2,
  parameter int unsigned          RW           = 10,
  parameter logic [NUM_CH*RW-1:0] INIT_RATIO   = {10'd12, 10'd12},
  parameter int unsigned          RST_CYCLES   = 16,
  parameter int unsigned          LOCK_FILT    = 64,
  parameter int unsigned          LOCK_TIMEOUT = 65536,
  parameter int unsigned          MAX_RETRY    = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 pll_lock,
  pll_dyn_ctrl_if.slave        cfg,
  output logic                 pll_rst,
  output logic [NUM_CH*RW-1:0] ratio_o,
  output logic [NUM_CH*RW-1:0] duty_o,
  output logic                 locked,
  output logic                 clk_rst_n,
  output logic                 fail,
  output logic [7:0]           relock_cnt
);

  // One counter serves both the reset hold and the lock timeout.
  localparam int unsigned CntMax = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned CW     = $clog2(CntMax + 1);
  localparam int unsigned FW     = $clog2(LOCK_FILT + 1);
  localparam int unsigned RTW    = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {StRst, StWaitLock, StStable, StFail} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          filt_q, filt_d;
  logic [RTW-1:0]         retry_q, retry_d;
  logic [7:0]             relock_q, relock_d;
  logic [NUM_CH*RW-1:0]   ratio_q, ratio_d;
  logic                   err_q, err_d;
  logic                   lock_meta, lock_s;
  logic                   accept, legal;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign accept = cfg.cfg_valid & cfg.cfg_ready;
  assign legal  = (cfg.cfg_ratio != '0) && (32'(cfg.cfg_ch) < NUM_CH);

  // Next-state logic: lock sequencing first, then an accepted request overrides the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    ratio_d  = ratio_q;
    err_d    = 1'b0;

    unique case (state_q)
      StRst: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = StWaitLock;
      end
      StWaitLock: begin
        cnt_d  = cnt_q + CW'(1);
        filt_d = lock_s ? filt_q + FW'(1) : '0;
        if (lock_s && (filt_q == FW'(LOCK_FILT - 1))) begin
          state_d = StStable;
          retry_d = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + RTW'(1);
          state_d = (retry_d == RTW'(MAX_RETRY)) ? StFail : StRst;
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d  = StRst;
          relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
        end
      end
      StFail: begin
        state_d = StFail;
      end
    endcase

    if (accept) begin
      if (legal) begin
        state_d = StRst;
        retry_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg.cfg_ch == 3'(i)) ratio_d[i*RW +: RW] = cfg.cfg_ratio;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Counters restart on every state entry.
    if (state_d != state_q) begin
      cnt_d  = '0;
      filt_d = '0;
    end
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= StRst;
      cnt_q    <= '0;
      filt_q   <= '0;
      retry_q  <= '0;
      relock_q <= '0;
      ratio_q  <= INIT_RATIO;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      retry_q  <= retry_d;
      relock_q <= relock_d;
      ratio_q  <= ratio_d;
      err_q    <= err_d;
    end
  end

  assign pll_rst       = (state_q == StRst) || (state_q == StFail);
  assign locked        = (state_q == StStable);
  assign clk_rst_n     = (state_q == StStable);
  assign fail          = (state_q == StFail);
  assign cfg.cfg_ready = (state_q == StStable) || (state_q == StFail);
  assign cfg.cfg_err   = err_q;
  assign ratio_o       = ratio_q;
  // Duty field equal to the divider gives 50% duty.
  assign duty_o        = ratio_q;
  assign relock_cnt    = relock_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed bench for pll_dyn_ctrl. Lock timeout is shortened so the retry/fail path fits a
// short run; all other parameters keep their defaults.
module tb_pll_dyn_ctrl;

  localparam int unsigned TMO = 1000;
  localparam logic [31:0] InitRatio = 32'd12300;  // {10'd12,10'd12}

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        pll_lock;
  logic        pll_rst;
  logic [19:0] ratio_o;
  logic [19:0] duty_o;
  logic        locked;
  logic        clk_rst_n;
  logic        fail;
  logic [7:0]  relock_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pll_dyn_ctrl_if #(.RW(10)) cfg_if ();

  pll_dyn_ctrl #(
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pll_lock   (pll_lock),
    .cfg        (cfg_if),
    .pll_rst    (pll_rst),
    .ratio_o    (ratio_o),
    .duty_o     (duty_o),
    .locked     (locked),
    .clk_rst_n  (clk_rst_n),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance n clock cycles, landing on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_locked(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !locked; i++) step(1);
    check_eq(tag, {31'd0, locked}, 32'd1);
  endtask

  task automatic send_cfg(input logic [2:0] ch, input logic [9:0] ratio);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_ratio = ratio;
    step(1);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    sys_rst_n        = 1'b0;
    pll_lock         = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_ratio = '0;
    step(3);

    // Reset values
    check_eq("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_clk_rst_n", {31'd0, clk_rst_n}, 32'd0);
    check_eq("rst_fail", {31'd0, fail}, 32'd0);
    check_eq("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    check_eq("rst_err", {31'd0, cfg_if.cfg_err}, 32'd0);
    check_eq("rst_relock", {24'd0, relock_cnt}, 32'd0);
    check_eq("rst_ratio", {12'd0, ratio_o}, InitRatio);
    check_eq("rst_duty", {12'd0, duty_o}, InitRatio);

    // pll_rst held exactly 16 cycles after release
    sys_rst_n = 1'b1;
    step(15);
    check_eq("prst_hold15", {31'd0, pll_rst}, 32'd1);
    step(1);
    check_eq("prst_drop16", {31'd0, pll_rst}, 32'd0);

    // Lock rises 100 cycles after release; locked appears 2+64 edges later
    step(84);
    pll_lock = 1'b1;
    step(65);
    check_eq("lock_65", {31'd0, locked}, 32'd0);
    step(1);
    check_eq("lock_66", {31'd0, locked}, 32'd1);
    check_eq("lock_clk_rst_n", {31'd0, clk_rst_n}, 32'd1);
    check_eq("lock_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);

    // Reprogram ch1 to 8
    send_cfg(3'd1, 10'd8);
    check_eq("cfg_ratio", {12'd0, ratio_o}, 32'd8204);
    check_eq("cfg_duty", {12'd0, duty_o}, 32'd8204);
    check_eq("cfg_locked", {31'd0, locked}, 32'd0);
    check_eq("cfg_clk_rst_n", {31'd0, clk_rst_n}, 32'd0);
    check_eq("cfg_err_legal", {31'd0, cfg_if.cfg_err}, 32'd0);
    step(15);
    check_eq("cfg_prst15", {31'd0, pll_rst}, 32'd1);
    step(1);
    check_eq("cfg_prst16", {31'd0, pll_rst}, 32'd0);
    step(63);
    check_eq("cfg_relock63", {31'd0, locked}, 32'd0);
    step(1);
    check_eq("cfg_relock64", {31'd0, locked}, 32'd1);

    // Illegal requests: zero ratio, out-of-range channel
    send_cfg(3'd0, 10'd0);
    check_eq("bad0_err", {31'd0, cfg_if.cfg_err}, 32'd1);
    check_eq("bad0_ratio", {12'd0, ratio_o}, 32'd8204);
    check_eq("bad0_locked", {31'd0, locked}, 32'd1);
    step(1);
    check_eq("bad0_pulse", {31'd0, cfg_if.cfg_err}, 32'd0);
    send_cfg(3'd2, 10'd5);
    check_eq("bad2_err", {31'd0, cfg_if.cfg_err}, 32'd1);
    check_eq("bad2_ratio", {12'd0, ratio_o}, 32'd8204);
    check_eq("bad2_locked", {31'd0, locked}, 32'd1);
    step(1);
    check_eq("bad2_pulse", {31'd0, cfg_if.cfg_err}, 32'd0);
    check_eq("bad2_pll_rst", {31'd0, pll_rst}, 32'd0);

    // 5-cycle lock drop in STABLE
    pll_lock = 1'b0;
    step(2);
    check_eq("drop_still", {31'd0, locked}, 32'd1);
    step(1);
    check_eq("drop_locked", {31'd0, locked}, 32'd0);
    check_eq("drop_relock1", {24'd0, relock_cnt}, 32'd1);
    step(2);
    pll_lock = 1'b1;
    wait_locked("drop_relocked", 200);

    // Drive the loss counter to saturation
    for (int i = 2; i <= 300; i++) begin
      pll_lock = 1'b0;
      step(3);
      pll_lock = 1'b1;
      wait_locked("drop_loop", 200);
      if (i == 254) check_eq("relock_254", {24'd0, relock_cnt}, 32'd254);
      if (i == 255) check_eq("relock_255", {24'd0, relock_cnt}, 32'd255);
    end
    check_eq("relock_sat", {24'd0, relock_cnt}, 32'd255);

    // Lock lost for good: three timeouts then FAIL
    pll_lock = 1'b0;
    step(3);
    step(1015);
    check_eq("tmo1_before", {31'd0, pll_rst}, 32'd0);
    step(1);
    check_eq("tmo1_after", {31'd0, pll_rst}, 32'd1);
    check_eq("tmo1_nofail", {31'd0, fail}, 32'd0);
    step(2031);
    check_eq("tmo3_before", {31'd0, fail}, 32'd0);
    step(1);
    check_eq("tmo3_fail", {31'd0, fail}, 32'd1);
    check_eq("fail_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_eq("fail_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    check_eq("fail_locked", {31'd0, locked}, 32'd0);
    step(50);
    check_eq("fail_sticky", {31'd0, fail}, 32'd1);

    // Legal request leaves FAIL and retries
    send_cfg(3'd0, 10'd20);
    check_eq("exit_fail", {31'd0, fail}, 32'd0);
    check_eq("exit_ratio", {12'd0, ratio_o}, 32'd8212);
    check_eq("exit_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_eq("exit_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    step(20);
    check_eq("retry_wait", {31'd0, pll_rst}, 32'd0);

    // Reset mid-WAIT_LOCK restores everything
    sys_rst_n = 1'b0;
    step(1);
    check_eq("mrst_ratio", {12'd0, ratio_o}, InitRatio);
    check_eq("mrst_duty", {12'd0, duty_o}, InitRatio);
    check_eq("mrst_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_eq("mrst_fail", {31'd0, fail}, 32'd0);
    check_eq("mrst_relock", {24'd0, relock_cnt}, 32'd0);
    check_eq("mrst_locked", {31'd0, locked}, 32'd0);
    check_eq("mrst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);

    // One-cycle lock glitch in WAIT_LOCK restarts the filter
    sys_rst_n = 1'b1;
    step(16);
    pll_lock = 1'b1;
    step(30);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(65);
    check_eq("glitch_65", {31'd0, locked}, 32'd0);
    step(1);
    check_eq("glitch_66", {31'd0, locked}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
